// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared types, constants and write-collision arbitration for tdp_ram_mp
//
// Contents:
//   state_e      : init/ready state of the clear sequence
//   BYTE_LANES   : byte lanes of a default-width (8-bit) word
//   MAX_*        : upper bounds used to size the arbitration vectors
//   winner_mask  : per-port, per-lane mask of the writes that actually land
package tdp_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int BYTE_LANES         = DEFAULT_DATA_WIDTH / 8;

  // Arbitration vectors are sized for the largest supported configuration;
  // callers zero-extend their narrower vectors into these.
  localparam int MAX_PORTS = 4;
  localparam int MAX_LANES = 16;
  localparam int MAX_AW    = 32;

  typedef logic [MAX_PORTS-1:0][MAX_LANES-1:0] lane_mask_t;
  typedef logic [MAX_PORTS-1:0][MAX_AW-1:0]    addr_vec_t;

  // A lane of port p lands unless a lower-indexed port writes the same lane
  // of the same address in the same cycle.
  function automatic lane_mask_t winner_mask(
    input logic [MAX_PORTS-1:0] we,
    input lane_mask_t           be,
    input addr_vec_t            addr
  );
    lane_mask_t win;
    win = '0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      for (int l = 0; l < MAX_LANES; l++) begin
        if (we[p] && be[p][l]) begin
          win[p][l] = 1'b1;
          for (int q = 0; q < p; q++) begin
            if (we[q] && be[q][l] && (addr[q] == addr[p])) begin
              win[p][l] = 1'b0;
            end
          end
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/tdp_ram_init_fsm.sv
// rtl/tdp_ram_init_fsm.sv - post-reset clear sweep of the RAM array
//
// Ports:
//   clk_i        : clock, rising edge
//   resetn_i     : asynchronous active-low reset
//   ready_o      : high once every address has been cleared
//   init_we_o    : clear-write strobe into the array
//   init_addr_o  : address being cleared this cycle
module tdp_ram_init_fsm
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  output logic                  ready_o,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last address is cleared on the same edge that moves us to READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == READY);
    init_we_o   = (state_q == INIT);
    init_addr_o = cnt_q;
  end

endmodule

// File: rtl/tdp_ram_mp.sv
// rtl/tdp_ram_mp.sv - parametrised multi-port RAM with byte enables and collision reporting
//
// Optional feature macro: TDP_RAM_OUT_REG_EN (extra output register stage,
// read latency 2 instead of 1).
//
// Ports (port p occupies slice p of every per-port vector):
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   we / re    : per-port write / read enables
//   be         : per-port byte enables
//   addr       : per-port address
//   data       : per-port write data
//   out        : per-port read data, held between reads
//   out_valid  : one-cycle pulse per completed read
//   coll       : one-cycle pulse when the port lost a same-address write
//   ready      : high once the post-reset clear sweep has finished
module tdp_ram_mp
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PORTS   = 2,
  parameter int WRITE_FIRST = 0
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [NUM_PORTS-1:0]                 we,
  input  logic [NUM_PORTS-1:0]                 re,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  be,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]      out,
  output logic [NUM_PORTS-1:0]                 out_valid,
  output logic [NUM_PORTS-1:0]                 coll,
  output logic                                 ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data;
  logic [NUM_PORTS-1:0][LANES-1:0]      port_be;

  assign port_addr = addr;
  assign port_data = data;
  assign port_be   = be;

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  tdp_ram_init_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_fsm (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .ready_o     (ready),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  // A write with no byte enabled is not a write at all: it neither changes
  // memory nor takes part in collision detection.
  logic [NUM_PORTS-1:0] wr_req;
  logic [NUM_PORTS-1:0] rd_req;

  always_comb begin
    wr_req = '0;
    rd_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_req[p] = ready && we[p] && (port_be[p] != '0);
      rd_req[p] = ready && re[p];
    end
  end

  logic [MAX_PORTS-1:0]            we_ext;
  lane_mask_t                      be_ext;
  addr_vec_t                       addr_ext;
  lane_mask_t                      win_ext;
  logic [NUM_PORTS-1:0][LANES-1:0] win;

  always_comb begin
    we_ext   = '0;
    be_ext   = '0;
    addr_ext = '0;
    win      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      we_ext[p]                     = wr_req[p];
      be_ext[p][LANES-1:0]          = port_be[p];
      addr_ext[p][ADDR_WIDTH-1:0]   = port_addr[p];
    end
    win_ext = winner_mask(we_ext, be_ext, addr_ext);
    for (int p = 0; p < NUM_PORTS; p++) begin
      win[p] = win_ext[p][LANES-1:0];
    end
  end

  // Only the configured ports/lanes of the wide arbitration result are used.
  logic unused_win_ext;
  assign unused_win_ext = ^win_ext;

  // Storage. Sweep writes happen only before ready and port writes only
  // after, so the two never target the array in the same cycle.
  word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int l = 0; l < LANES; l++) begin
        if (win[p][l]) begin
          mem_q[port_addr[p]][l*8 +: 8] <= port_data[p][l*8 +: 8];
        end
      end
    end
  end

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_out_q, rd_out_d;
  logic [NUM_PORTS-1:0]                 rd_valid_q, rd_valid_d;
  logic [NUM_PORTS-1:0]                 coll_q, coll_d;

  // Reads see the array before this edge's writes, so other ports always get
  // the old word. In write-first mode a port sees its own landed lanes only;
  // lanes it lost to a lower port still return the old data.
  always_comb begin
    word_t rd_word;
    rd_word    = '0;
    rd_out_d   = rd_out_q;
    rd_valid_d = '0;
    coll_d     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word = mem_q[port_addr[p]];
      if (WRITE_FIRST != 0) begin
        for (int l = 0; l < LANES; l++) begin
          if (win[p][l]) begin
            rd_word[l*8 +: 8] = port_data[p][l*8 +: 8];
          end
        end
      end
      if (rd_req[p]) begin
        rd_out_d[p]   = rd_word;
        rd_valid_d[p] = 1'b1;
      end
      // Any lower-indexed writer at the same address makes this port a loser,
      // regardless of whether their lanes overlap.
      for (int q = 0; q < p; q++) begin
        if (wr_req[q] && wr_req[p] && (port_addr[q] == port_addr[p])) begin
          coll_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_out_q   <= '0;
      rd_valid_q <= '0;
      coll_q     <= '0;
    end else begin
      rd_out_q   <= rd_out_d;
      rd_valid_q <= rd_valid_d;
      coll_q     <= coll_d;
    end
  end

`ifdef TDP_RAM_OUT_REG_EN
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_q;
  logic [NUM_PORTS-1:0]                 out_valid_q;
  logic [NUM_PORTS-1:0]                 coll_out_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q       <= '0;
      out_valid_q <= '0;
      coll_out_q  <= '0;
    end else begin
      out_q       <= rd_out_q;
      out_valid_q <= rd_valid_q;
      coll_out_q  <= coll_q;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign coll      = coll_out_q;
`else
  assign out       = rd_out_q;
  assign out_valid = rd_valid_q;
  assign coll      = coll_q;
`endif

endmodule

// File: tb/tb_tdp_ram_mp.sv
// tb/tb_tdp_ram_mp.sv - self-checking bench for tdp_ram_mp (default and wide write-first builds)
module tb_tdp_ram_mp;

`ifdef TDP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic resetn;

  logic [1:0]  we0, re0, be0, ov0, coll0;
  logic [19:0] addr0;
  logic [15:0] data0, out0;
  logic        ready0;

  logic [2:0]  we1, re1, ov1, coll1;
  logic [5:0]  be1;
  logic [11:0] addr1;
  logic [47:0] data1, out1;
  logic        ready1;

  int checks = 0;
  int errors = 0;

  tdp_ram_mp u_dut0 (
    .clk (clk), .resetn (resetn), .we (we0), .re (re0), .be (be0), .addr (addr0),
    .data (data0), .out (out0), .out_valid (ov0), .coll (coll0), .ready (ready0)
  );

  tdp_ram_mp #(
    .ADDR_WIDTH (4), .DATA_WIDTH (16), .NUM_PORTS (3), .WRITE_FIRST (1)
  ) u_dut1 (
    .clk (clk), .resetn (resetn), .we (we1), .re (re1), .be (be1), .addr (addr1),
    .data (data1), .out (out1), .out_valid (ov1), .coll (coll1), .ready (ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle1_settle();
    we1 = '0; re1 = '0; be1 = '0;
    repeat (LAT - 1) cyc();
  endtask

  typedef struct {
    logic [1:0] we, re, be;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1, o0, o1;
    logic [1:0] ev, ec;
  } vec_t;

  vec_t tbl [15];

  typedef struct {
    logic [47:0] o;
    logic [2:0]  v;
    logic [2:0]  c;
  } exp1_t;

  exp1_t       exq[$];
  logic [15:0] mem1 [16];
  logic [15:0] mo [3];

  // Reference: build a claim table (first port in index order owns each
  // address/lane), read pre-edge memory, then commit the claimed bytes.
  task automatic model1_step();
    exp1_t       e;
    int          owner [16][2];
    logic [3:0]  a [3];
    logic [15:0] w;
    logic [2:0]  writes;
    for (int i = 0; i < 16; i++) for (int l = 0; l < 2; l++) owner[i][l] = -1;
    for (int p = 0; p < 3; p++) begin
      a[p]      = addr1[p*4 +: 4];
      writes[p] = we1[p] && (be1[p*2 +: 2] != 2'b00);
    end
    for (int p = 0; p < 3; p++)
      for (int l = 0; l < 2; l++)
        if (we1[p] && be1[p*2+l] && owner[a[p]][l] < 0) owner[a[p]][l] = p;
    e.v = '0;
    e.c = '0;
    e.o = '0;
    for (int p = 0; p < 3; p++) begin
      for (int q = 0; q < p; q++)
        if (writes[q] && writes[p] && a[q] == a[p]) e.c[p] = 1'b1;
      if (re1[p]) begin
        w = mem1[a[p]];
        for (int l = 0; l < 2; l++)
          if (owner[a[p]][l] == p) w[l*8 +: 8] = data1[p*16 + l*8 +: 8];
        mo[p]  = w;
        e.v[p] = 1'b1;
      end
      e.o[p*16 +: 16] = mo[p];
    end
    for (int i = 0; i < 16; i++)
      for (int l = 0; l < 2; l++)
        if (owner[i][l] >= 0) mem1[i][l*8 +: 8] = data1[owner[i][l]*16 + l*8 +: 8];
    exq.push_back(e);
  endtask

  initial begin
    exp1_t e;
    //          we     re     be     a0      a1      d0     d1     o0     o1     ev     ec
    tbl[0]  = '{2'b00, 2'b11, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 10'h010, 10'h000, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00};
    tbl[2]  = '{2'b00, 2'b10, 2'b00, 10'h000, 10'h010, 8'h00, 8'h00, 8'h00, 8'hA5, 2'b10, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 2'b11, 10'h020, 10'h020, 8'h11, 8'h22, 8'h00, 8'hA5, 2'b00, 2'b10};
    tbl[4]  = '{2'b00, 2'b11, 2'b00, 10'h020, 10'h020, 8'h00, 8'h00, 8'h11, 8'h11, 2'b11, 2'b00};
    tbl[5]  = '{2'b01, 2'b00, 2'b01, 10'h030, 10'h000, 8'h33, 8'h00, 8'h11, 8'h11, 2'b00, 2'b00};
    tbl[6]  = '{2'b01, 2'b11, 2'b01, 10'h030, 10'h030, 8'h55, 8'h00, 8'h33, 8'h33, 2'b11, 2'b00};
    tbl[7]  = '{2'b00, 2'b11, 2'b00, 10'h030, 10'h030, 8'h00, 8'h00, 8'h55, 8'h55, 2'b11, 2'b00};
    tbl[8]  = '{2'b01, 2'b00, 2'b00, 10'h030, 10'h000, 8'h77, 8'h00, 8'h55, 8'h55, 2'b00, 2'b00};
    tbl[9]  = '{2'b00, 2'b01, 2'b00, 10'h030, 10'h000, 8'h00, 8'h00, 8'h55, 8'h55, 2'b01, 2'b00};
    tbl[10] = '{2'b11, 2'b00, 2'b11, 10'h040, 10'h041, 8'h01, 8'h02, 8'h55, 8'h55, 2'b00, 2'b00};
    tbl[11] = '{2'b00, 2'b11, 2'b00, 10'h041, 10'h040, 8'h00, 8'h00, 8'h02, 8'h01, 2'b11, 2'b00};
    tbl[12] = '{2'b01, 2'b10, 2'b01, 10'h050, 10'h040, 8'hC3, 8'h00, 8'h02, 8'h01, 2'b10, 2'b00};
    tbl[13] = '{2'b10, 2'b01, 2'b10, 10'h050, 10'h040, 8'h00, 8'hFF, 8'hC3, 8'h01, 2'b01, 2'b00};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 8'hC3, 8'h01, 2'b00, 2'b00};

    resetn = 1'b0;
    we0 = '0; re0 = '0; be0 = '0; addr0 = '0; data0 = '0;
    we1 = '0; re1 = '0; be1 = '0; addr1 = '0; data1 = '0;
    repeat (3) cyc();
    chk("reset_out", 64'(out0), 64'h0);
    chk("reset_out_valid", 64'(ov0), 64'h0);
    chk("reset_coll", 64'(coll0), 64'h0);
    chk("reset_ready", 64'(ready0), 64'h0);

    // Sweep: ready low for 1023 edges, high on edge 1024; a request issued
    // mid-sweep must be ignored (no read pulse, write to 0 must not stick).
    resetn = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      if (k == 10) begin
        we0 = 2'b01; be0 = 2'b01; re0 = 2'b10; addr0 = '0; data0 = 16'h0099;
      end else begin
        we0 = '0; be0 = '0; re0 = '0;
      end
      cyc();
      chk($sformatf("sweep_ready_k%0d", k), 64'(ready0), 64'(k == 1024));
      chk($sformatf("sweep_no_valid_k%0d", k), 64'(ov0), 64'h0);
    end

    for (int c = 0; c < 15 + LAT - 1; c++) begin
      if (c < 15) begin
        we0 = tbl[c].we; re0 = tbl[c].re; be0 = tbl[c].be;
        addr0 = {tbl[c].a1, tbl[c].a0}; data0 = {tbl[c].d1, tbl[c].d0};
      end else begin
        we0 = '0; re0 = '0; be0 = '0;
      end
      cyc();
      if (c - LAT + 1 >= 0) begin
        int k;
        k = c - LAT + 1;
        chk($sformatf("tbl%0d_out0", k), 64'(out0[7:0]), 64'(tbl[k].o0));
        chk($sformatf("tbl%0d_out1", k), 64'(out0[15:8]), 64'(tbl[k].o1));
        chk($sformatf("tbl%0d_valid", k), 64'(ov0), 64'(tbl[k].ev));
        chk($sformatf("tbl%0d_coll", k), 64'(coll0), 64'(tbl[k].ec));
      end
    end
    we0 = '0; re0 = '0; be0 = '0;

    // Wide write-first build: partial byte write, then own/cross-port
    // read-during-write.
    chk("dut1_ready", 64'(ready1), 64'h1);
    we1 = 3'b001; be1 = 6'b000001; addr1 = 12'h000; data1 = 48'hBEEF;
    cyc();
    we1 = '0; be1 = '0; re1 = 3'b001; addr1 = 12'h000;
    cyc();
    idle1_settle();
    chk("be_partial_out", 64'(out1[15:0]), 64'h00EF);
    chk("be_partial_valid", 64'(ov1), 64'h1);

    we1 = 3'b001; be1 = 6'b000011; addr1 = 12'h001; data1 = 48'h0033;
    cyc();
    we1 = 3'b001; re1 = 3'b011; be1 = 6'b000011; addr1 = 12'h011; data1 = 48'h0055;
    cyc();
    idle1_settle();
    chk("wf_own_port", 64'(out1[15:0]), 64'h0055);
    chk("wf_cross_port", 64'(out1[31:16]), 64'h0033);
    chk("wf_valid", 64'(ov1), 64'h3);

    re1 = 3'b111; addr1 = 12'h222;
    cyc();
    idle1_settle();
    chk("dut1_clear_outs", 64'(out1), 64'h0);

    for (int i = 0; i < 16; i++) mem1[i] = '0;
    mem1[0] = 16'h00EF;
    mem1[1] = 16'h0055;
    for (int p = 0; p < 3; p++) mo[p] = '0;

    // Randomised traffic on a few addresses so collisions are frequent.
    for (int c = 0; c < 400 + LAT; c++) begin
      if (c < 400) begin
        we1 = 3'($urandom); re1 = 3'($urandom); be1 = 6'($urandom);
        data1 = {16'($urandom), 32'($urandom)};
        for (int p = 0; p < 3; p++) addr1[p*4 +: 4] = 4'($urandom_range(0, 3));
      end else begin
        we1 = '0; re1 = '0; be1 = '0;
      end
      model1_step();
      cyc();
      if (exq.size() == LAT) begin
        e = exq.pop_front();
        chk($sformatf("rnd_out_c%0d", c), 64'(out1), 64'(e.o));
        chk($sformatf("rnd_valid_c%0d", c), 64'(ov1), 64'(e.v));
        chk($sformatf("rnd_coll_c%0d", c), 64'(coll1), 64'(e.c));
      end
    end
    we1 = '0; re1 = '0; be1 = '0;

    // Reset while a read of 0x010 (holding 0xA5) is pending.
    re0 = 2'b01; addr0 = {10'h000, 10'h010};
    if (LAT == 2) begin
      cyc();
      re0 = '0;
    end
    resetn = 1'b0;
    #1;
    chk("rst_mid_out", 64'(out0), 64'h0);
    chk("rst_mid_valid", 64'(ov0), 64'h0);
    chk("rst_mid_ready", 64'(ready0), 64'h0);
    re0 = '0;
    repeat (3) begin
      cyc();
      chk("rst_hold_valid", 64'(ov0), 64'h0);
      chk("rst_hold_ready", 64'(ready0), 64'h0);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      cyc();
      if (k >= 1023) chk($sformatf("resweep_ready_k%0d", k), 64'(ready0), 64'(k == 1024));
    end
    re0 = 2'b01; addr0 = {10'h000, 10'h010};
    cyc();
    re0 = '0;
    repeat (LAT - 1) cyc();
    chk("resweep_cleared", 64'(out0[7:0]), 64'h0);
    chk("resweep_valid", 64'(ov0), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdp_ram_mp.md
# tdp_ram_mp

Parametrised multi-port RAM, the next generation of the team's true dual-port RAM. It adds a configurable port count, per-byte write enables, a fixed write-collision policy, a selectable read-during-write mode and a hardware clear sequence after reset. It is the DUT behind the TDP RAM UVC, and its per-port signals keep the existing we/re/addr/data/out naming.

## Interface
- ADDR_WIDTH, 10, address bits per port; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 8, word width; must be a multiple of 8
- NUM_PORTS, 2, number of independent read/write ports (1..4)
- WRITE_FIRST, 0, same-port read during write: 0 returns old word, 1 returns new word
- clk  input  1  single clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- we  input  NUM_PORTS  per-port write enable
- re  input  NUM_PORTS  per-port read enable
- be  input  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, port p at slice p
- addr  input  NUM_PORTS*ADDR_WIDTH  per-port address
- data  input  NUM_PORTS*DATA_WIDTH  per-port write data
- out  output  NUM_PORTS*DATA_WIDTH  per-port read data
- out_valid  output  NUM_PORTS  read data valid, one-cycle pulse per read
- coll  output  NUM_PORTS  port lost a write collision; one-cycle pulse
- ready  output  1  high once the init sweep is done; requests are accepted only while high

## Operation
- FSM states are INIT and READY.
- Reset sends the FSM to INIT with the sweep counter at 0.
- INIT writes zero to address counter and increments the counter each cycle. When counter == DEPTH-1 is written, the FSM goes to READY.
- All requests are ignored while ready=0.
- Writes: for each lane i with be[i]=1, the lane takes that port's data at the rising edge. A write with be all zero is a no-op.
- Reads: re=1 captures mem[addr] into out.
- Write collision: two or more ports write the same address in one cycle.
  - Per byte lane, the lowest-indexed port with that lane enabled wins.
  - Every other writing port at that address asserts coll.
  - coll is asserted whether or not a losing port's lanes overlapped.
- Cross-port read/write to the same address: the reader gets the old word, regardless of WRITE_FIRST.
- Same-port we=1 and re=1: the result follows WRITE_FIRST, per lane. Lanes not written return the old data.
- Read with we=0 and re=0: out holds its last value and out_valid=0.
- Address wrap-around does not apply; every address is in range.

## Timing
- Reset values: out=0, out_valid=0, coll=0, ready=0. Memory contents are undefined until the sweep ends.
- ready rises DEPTH cycles after resetn deasserts (1024 cycles at the default).
- Read latency is 1 cycle: request sampled at edge N, out and out_valid valid after edge N+1. The latency becomes 2 when the Configuration macro is defined.
- Write latency: a read issued the cycle after a write returns the new data.
- coll pulses in the cycle after the colliding request, aligned with out_valid timing at latency 1.
- Back-to-back requests on every port, every cycle, with no bubbles.
- Reset mid-operation clears all outputs at once, cancels in-flight reads (no out_valid) and restarts the sweep from address 0.

## Configuration
- Macro: TDP_RAM_OUT_REG_EN.
- Defined: one extra output register stage on out, out_valid and coll. Read latency is 2, and the registers reset to 0.
- Undefined: read latency is 1 and there is no extra stage.
- Collision and read-mode behaviour is identical in both builds, only delayed.

## Structure
- Package tdp_ram_pkg holds:
  - the state enum (INIT, READY)
  - constant BYTE_LANES = DATA_WIDTH/8
  - a function computing the per-lane winner mask from the we, be and addr vectors
- Sub-module tdp_ram_init_fsm owns the state, the sweep counter, ready, and the init write port into the array.
- The top level contains the array, the per-port datapath and the collision logic.

## Test plan
- Reset, then idle: ready stays 0 for 1023 cycles and rises on cycle 1024. A read at 0x3FF returns 0x00.
- Port0 writes 0xA5 at 0x010, next cycle port1 reads 0x010: out port1 = 0xA5 and out_valid pulses 1 cycle later (2 with TDP_RAM_OUT_REG_EN).
- Port0 and port1 write 0x11 and 0x22 to 0x020 in the same cycle: coll[1]=1 and coll[0]=0, and a later read returns 0x11.
- DATA_WIDTH=16, port0 writes 0xBEEF with be=2'b01 over 0x0000: a later read returns 0x00EF.
- Same-port write of 0x55 over 0x33 with re=1: returns 0x33 with WRITE_FIRST=0 and 0x55 with WRITE_FIRST=1. A port1 read in the same cycle always returns 0x33.
- resetn is pulsed low while a read is in flight: out_valid stays 0, ready drops, and the sweep restarts from address 0.
